// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART line arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned c_line_bytes = 34;
  localparam int unsigned c_line_bits  = 272;
  localparam int unsigned c_gap_cycles = 2;

  // Blank line: 32 spaces then CR LF, first character in the MSByte.
  localparam logic [c_line_bits-1:0] c_line_of_spaces = {{32{8'h20}}, 8'h0D, 8'h0A};

endpackage

// File: rtl/uart_line_arbiter_if.sv
// Producer/feeder side bundle of the UART line arbiter.
// master: producers + feeder monitor (drive requests, lines, valid beats).
// slave : the arbiter itself.
interface uart_line_arbiter_if #(
  parameter int unsigned PARM_NUM_REQ = 3
);
  import uart_arb_pkg::*;

  logic [PARM_NUM_REQ-1:0]             i_req;
  logic [PARM_NUM_REQ*c_line_bits-1:0] i_line;
  logic [PARM_NUM_REQ-1:0]             o_grant;
  logic [PARM_NUM_REQ-1:0]             o_ack;
  logic                                o_busy;
  logic                                o_feed_go;
  logic [c_line_bits-1:0]              o_feed_line;
  logic                                i_feed_valid;

  modport master (
    output i_req, i_line, i_feed_valid,
    input  o_grant, o_ack, o_busy, o_feed_go, o_feed_line
  );

  modport slave (
    input  i_req, i_line, i_feed_valid,
    output o_grant, o_ack, o_busy, o_feed_go, o_feed_line
  );

endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational winner select for the UART line arbiter.
// Default: round-robin starting at i_last+1 mod N.
// UART_ARB_FIXED_PRIORITY_EN defined: lowest set index wins, i_last ignored.
module uart_arb_rr_pick #(
  parameter int unsigned PARM_NUM_REQ = 3,
  parameter int unsigned IDX_W        = 2
) (
  input  logic [PARM_NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]        i_last,
  output logic [PARM_NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]        o_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

`ifdef UART_ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^i_last;

  // Lowest-index requester wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < PARM_NUM_REQ; i++) begin
      cand = IDX_W'(i);
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_idx          = cand;
        o_onehot[cand] = 1'b1;
      end
    end
  end
`else
  // Scan from last+1 around the ring; first set bit wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= PARM_NUM_REQ; i++) begin
      cand = IDX_W'((32'(i_last) + i) % PARM_NUM_REQ);
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_idx          = cand;
        o_onehot[cand] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_line_arbiter.sv
// Shares the single 34-byte UART TX line feeder among PARM_NUM_REQ producers.
// Latches the winner's line, holds go for the transfer, counts 34 valid beats,
// then forces a go-low gap before the next grant.
// Optional feature macro: UART_ARB_FIXED_PRIORITY_EN (fixed priority pick).
module uart_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned PARM_NUM_REQ = 3
) (
  input  logic                i_clk_20mhz,
  input  logic                i_rst_20mhz,
  uart_line_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (PARM_NUM_REQ > 1) ? $clog2(PARM_NUM_REQ) : 1;

  arb_state_e              state_q, state_d;
  logic [PARM_NUM_REQ-1:0] grant_q, grant_d;
  logic [PARM_NUM_REQ-1:0] ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    go_q, go_d;
  logic [c_line_bits-1:0]  line_q, line_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [5:0]              beat_q, beat_d;
  logic [1:0]              gap_q, gap_d;

  logic [PARM_NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]        win_idx;
  logic [c_line_bits-1:0]  win_line;

  uart_arb_rr_pick #(
    .PARM_NUM_REQ (PARM_NUM_REQ),
    .IDX_W        (IDX_W)
  ) u_pick (
    .i_req    (bus.i_req),
    .i_last   (last_q),
    .o_onehot (win_onehot),
    .o_idx    (win_idx)
  );

  // One-hot mux of the winning producer's line.
  always_comb begin
    win_line = '0;
    for (int unsigned k = 0; k < PARM_NUM_REQ; k++) begin
      if (win_onehot[k]) win_line = win_line | bus.i_line[k*c_line_bits +: c_line_bits];
    end
  end

  // Next-state and registered-output logic for IDLE/RUN/GAP.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    busy_d  = busy_q;
    go_d    = go_q;
    line_d  = line_q;
    last_d  = last_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          line_d  = win_line;
          grant_d = win_onehot;
          go_d    = 1'b1;
          busy_d  = 1'b1;
          last_d  = win_idx;
          beat_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_feed_valid) begin
          if (beat_q == 6'(c_line_bytes - 1)) begin
            go_d    = 1'b0;
            grant_d = '0;
            ack_d   = grant_q;
            beat_d  = '0;
            gap_d   = 2'(c_gap_cycles);
            state_d = ST_GAP;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      ST_GAP: begin
        // Leave on the cycle the counter reaches zero, giving 3 go-low cycles.
        if (gap_q <= 2'd1) begin
          gap_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        go_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      line_q  <= c_line_of_spaces;
      last_q  <= IDX_W'(PARM_NUM_REQ - 1);
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      line_q  <= line_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_ack       = ack_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_feed_go   = go_q;
  assign bus.o_feed_line = line_q;

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter: vector table of transfers plus
// hand-written reset-mid-transfer sequence.
module tb_uart_line_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned N = 3;
  localparam logic [271:0] BLANK = {{32{8'h20}}, 8'h0D, 8'h0A};

  logic clk = 1'b0;
  logic rst;
  always #25 clk = ~clk;

  uart_line_arbiter_if #(.PARM_NUM_REQ(N)) bus_if ();

  uart_line_arbiter #(.PARM_NUM_REQ(N)) dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .bus         (bus_if)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [271:0] lines [N];

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  exp_grant;
    int unsigned stall;
    bit          drop;
    bit          keep;
    bit          chk_lat;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [271:0] make_line(input int unsigned seed);
    logic [271:0] l;
    l = '0;
    for (int j = 0; j < 32; j++) l[271-8*j -: 8] = 8'(8'h41 + (seed + 32'(j)) % 26);
    l[15:0] = 16'h0D0A;
    return l;
  endfunction

  function automatic int unsigned idx_of(input logic [2:0] g);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 3; i++) if (g[i]) r = 32'(i);
    return r;
  endfunction

  task automatic drive_lines();
    bus_if.i_line = {lines[2], lines[1], lines[0]};
  endtask

  task automatic xfer(input vec_t v, input int unsigned vi);
    int unsigned  cnt;
    int unsigned  k;
    int unsigned  low;
    logic [271:0] exp_line;
    k = idx_of(v.exp_grant);
    if (!bus_if.o_feed_go) begin
      for (int i = 0; i < 3; i++) lines[i] = make_line(vi * 5 + 32'(i) * 7);
      drive_lines();
    end
    bus_if.i_req = v.req;
    cnt = 0;
    while (!bus_if.o_feed_go && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus_if.o_feed_go) begin
      n_cmp++;
      n_bad++;
      $display("FAIL go_timeout: vector %0d got no go within 20 cycles", vi);
      bus_if.i_req = '0;
      return;
    end
    if (v.chk_lat) chk("grant_latency", cnt, 32'd1);
    chk("grant", 32'(bus_if.o_grant), 32'(v.exp_grant));
    chk("busy_run", 32'(bus_if.o_busy), 32'd1);
    chk("ack_run", 32'(bus_if.o_ack), 32'd0);
    chk_line("line_at_grant", bus_if.o_feed_line, lines[k]);
    exp_line = lines[k];
    if (v.drop) begin
      bus_if.i_req = v.req & ~v.exp_grant;
      lines[k] = make_line(77);
      drive_lines();
    end
    @(negedge clk);
    for (int b = 0; b < 34; b++) begin
      if (b == 5 && v.stall > 0) begin
        bus_if.i_feed_valid = 1'b0;
        repeat (v.stall) @(negedge clk);
        chk("stall_go", 32'(bus_if.o_feed_go), 32'd1);
        chk("stall_grant", 32'(bus_if.o_grant), 32'(v.exp_grant));
      end
      if (b == 33) begin
        chk("go_before_last", 32'(bus_if.o_feed_go), 32'd1);
        chk("ack_before_last", 32'(bus_if.o_ack), 32'd0);
        for (int j = 0; j < 34; j++)
          chk("line_byte", 32'(bus_if.o_feed_line[271-8*j -: 8]), 32'(exp_line[271-8*j -: 8]));
      end
      bus_if.i_feed_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.i_feed_valid = 1'b0;
    chk("ack_pulse", 32'(bus_if.o_ack), 32'(v.exp_grant));
    chk("go_low_after", 32'(bus_if.o_feed_go), 32'd0);
    chk("grant_low_after", 32'(bus_if.o_grant), 32'd0);
    chk("busy_gap", 32'(bus_if.o_busy), 32'd1);
    if (!v.keep) bus_if.i_req = '0;
    low = 1;
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus_if.o_ack), 32'd0);
    if (v.keep) begin
      while (!bus_if.o_feed_go && low < 10) begin
        low++;
        @(negedge clk);
      end
      chk("go_low_gap", low, 32'd3);
    end
  endtask

  initial begin
    int unsigned cnt;
    rst = 1'b1;
    bus_if.i_req = '0;
    bus_if.i_feed_valid = 1'b0;
    for (int i = 0; i < 3; i++) lines[i] = make_line(32'(i));
    drive_lines();
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus_if.o_grant), 32'd0);
    chk("rst_ack", 32'(bus_if.o_ack), 32'd0);
    chk("rst_busy", 32'(bus_if.o_busy), 32'd0);
    chk("rst_go", 32'(bus_if.o_feed_go), 32'd0);
    chk_line("rst_line", bus_if.o_feed_line, BLANK);
    rst = 1'b0;
    @(negedge clk);

`ifdef UART_ARB_FIXED_PRIORITY_EN
    tbl[0] = '{3'b001, 3'b001, 0,   1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'b110, 3'b010, 0,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{3'b110, 3'b010, 0,   1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'b110, 3'b010, 0,   1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'b111, 3'b001, 0,   1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b100, 3'b100, 100, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'b011, 3'b001, 0,   1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'b010, 3'b010, 0,   1'b1, 1'b0, 1'b0};
`else
    tbl[0] = '{3'b001, 3'b001, 0,   1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'b111, 3'b010, 0,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 3'b100, 0,   1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'b111, 3'b001, 0,   1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b111, 3'b010, 0,   1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b101, 3'b100, 100, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'b011, 3'b001, 0,   1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'b010, 3'b010, 0,   1'b1, 1'b0, 1'b0};
`endif

    for (int unsigned i = 0; i < 8; i++) xfer(tbl[i], i);

    // Reset in the middle of a transfer, at beat 10.
    for (int i = 0; i < 3; i++) lines[i] = make_line(40 + 32'(i));
    drive_lines();
    bus_if.i_req = 3'b010;
    cnt = 0;
    while (!bus_if.o_feed_go && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("rstseq_grant", 32'(bus_if.o_grant), 32'b010);
    @(negedge clk);
    repeat (10) begin
      bus_if.i_feed_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.i_feed_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_go", 32'(bus_if.o_feed_go), 32'd0);
    chk("midrst_grant", 32'(bus_if.o_grant), 32'd0);
    chk("midrst_busy", 32'(bus_if.o_busy), 32'd0);
    chk("midrst_ack", 32'(bus_if.o_ack), 32'd0);
    chk_line("midrst_line", bus_if.o_feed_line, BLANK);
    rst = 1'b0;
    bus_if.i_req = '0;
    @(negedge clk);
    xfer('{3'b111, 3'b001, 0, 1'b0, 1'b0, 1'b1}, 20);

    bus_if.i_req = '0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
